// File: rtl/xadc_sample_ctrl.sv
// ---------------------------------------------------------------------------
// xadc_sample_ctrl
//   Request-side master for the XADC DRP handshake FSM. After reset it issues
//   two configuration writes, then periodic reads. Each read returns a 12-bit
//   conversion code that feeds a block average, running min/max and a
//   hysteretic over-threshold alarm.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   enable          permits periodic reads (config writes ignore it)
//   clr_minmax      one-cycle pulse, reinitialises min/max
//   rd, wr          request levels towards the handshake FSM
//   addr, data_in   write address / data towards the handshake FSM
//   fsm_data        data_out of the handshake FSM
//   fsm_valid       one-cycle completion pulse of the handshake FSM
//   cfg_done        high once both configuration writes have finished
//   sample          last code (fsm_data[15:4]), sample_valid pulses with it
//   avg             last window average, avg_valid pulses with it
//   min_code        smallest sample since reset / clear
//   max_code        largest sample since reset / clear
//   alarm           hysteretic flag, evaluated on every average update
//   timeout_err     sticky, set when any transaction times out
// ---------------------------------------------------------------------------
module xadc_sample_ctrl #(
    parameter logic [6:0]  CFG_ADDR0  = 7'h40,
    parameter logic [15:0] CFG_DATA0  = 16'h0003,
    parameter logic [6:0]  CFG_ADDR1  = 7'h41,
    parameter logic [15:0] CFG_DATA1  = 16'h2000,
    parameter int          SAMPLE_DIV = 1000,
    parameter int          TIMEOUT    = 4096,
    parameter int          AVG_LOG2   = 4,
    parameter logic [11:0] ALARM_HI   = 12'hB00,
    parameter logic [11:0] ALARM_HYST = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr_minmax,
    output logic        rd,
    output logic        wr,
    output logic [6:0]  addr,
    output logic [15:0] data_in,
    input  logic [15:0] fsm_data,
    input  logic        fsm_valid,
    output logic        cfg_done,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic [11:0] avg,
    output logic        avg_valid,
    output logic [11:0] min_code,
    output logic [11:0] max_code,
    output logic        alarm,
    output logic        timeout_err
);

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [11:0]      ALARM_LO = ALARM_HI - ALARM_HYST;

    typedef enum logic [2:0] {
        S_CFG0 = 3'd0,
        S_CFG1 = 3'd1,
        S_REL  = 3'd2,
        S_IDLE = 3'd3,
        S_READ = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    state_t             r_tgt, w_tgt_nxt;     // where REL goes next
    logic [TO_W-1:0]    r_to_cnt;
    logic [DIV_W-1:0]   r_tick;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_sum;
    logic [CNT_W-1:0]   r_win;
    logic [11:0]        w_code;
    logic [11:0]        w_avg_new;
    logic               w_req_st, w_done, w_tmo, w_take;

    logic               r_rd, r_wr, r_cfg_done, r_sample_valid, r_avg_valid;
    logic               r_alarm, r_timeout_err;
    logic [6:0]         r_addr;
    logic [15:0]        r_data_in;
    logic [11:0]        r_sample, r_avg, r_min, r_max;

    assign w_req_st  = (r_state == S_CFG0) || (r_state == S_CFG1) || (r_state == S_READ);
    assign w_done    = w_req_st && fsm_valid;
    // a valid arriving in the last allowed cycle wins over the timeout
    assign w_tmo     = w_req_st && !fsm_valid && (r_to_cnt == TO_LAST);
    assign w_take    = (r_state == S_READ) && fsm_valid;
    assign w_code    = 12'(fsm_data >> 4);
    assign w_sum     = r_acc + ACC_W'(w_code);
    assign w_avg_new = w_sum[ACC_W-1:AVG_LOG2];

    // State and REL-target registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CFG0;
            r_tgt   <= S_CFG1;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        case (r_state)
            S_CFG0: begin
                if (w_done || w_tmo) begin
                    w_state_nxt = S_REL;
                    w_tgt_nxt   = S_CFG1;
                end else begin
                    w_state_nxt = S_CFG0;
                end
            end
            S_CFG1: begin
                if (w_done || w_tmo) begin
                    w_state_nxt = S_REL;
                    w_tgt_nxt   = S_IDLE;
                end else begin
                    w_state_nxt = S_CFG1;
                end
            end
            S_REL:  w_state_nxt = r_tgt;
            S_IDLE: begin
                if ((r_tick == {DIV_W{1'b0}}) && enable) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (w_done || w_tmo) begin
                    w_state_nxt = S_REL;
                    w_tgt_nxt   = S_IDLE;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            default: begin
                w_state_nxt = S_CFG0;
                w_tgt_nxt   = S_CFG1;
            end
        endcase
    end

    // Request outputs, registered from the next state so they track it exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= 7'h00;
            r_data_in <= 16'h0000;
        end else begin
            r_rd <= (w_state_nxt == S_READ);
            r_wr <= (w_state_nxt == S_CFG0) || (w_state_nxt == S_CFG1);
            case (w_state_nxt)
                S_CFG0: begin
                    r_addr    <= CFG_ADDR0;
                    r_data_in <= CFG_DATA0;
                end
                S_CFG1: begin
                    r_addr    <= CFG_ADDR1;
                    r_data_in <= CFG_DATA1;
                end
                default: begin
                    r_addr    <= r_addr;
                    r_data_in <= r_data_in;
                end
            endcase
        end
    end

    // Per-transaction timeout counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= {TO_W{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_to_cnt <= {TO_W{1'b0}};
            end else if (w_req_st) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= {TO_W{1'b0}};
            end
            if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Sample-interval tick: reload on IDLE entry, count down, hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= {DIV_W{1'b0}};
        end else if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE)) begin
            r_tick <= DIV_LOAD;
        end else if ((r_state == S_IDLE) && (r_tick != {DIV_W{1'b0}})) begin
            r_tick <= r_tick - DIV_W'(1);
        end else begin
            r_tick <= r_tick;
        end
    end

    // Configuration-complete flag, set when REL hands over to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_done <= 1'b0;
        end else if ((r_state == S_REL) && (r_tgt == S_IDLE)) begin
            r_cfg_done <= 1'b1;
        end else begin
            r_cfg_done <= r_cfg_done;
        end
    end

    // Sample capture and running min/max
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample       <= 12'h000;
            r_sample_valid <= 1'b0;
            r_min          <= 12'hFFF;
            r_max          <= 12'h000;
        end else begin
            r_sample_valid <= w_take;
            if (w_take) begin
                r_sample <= w_code;
                if (clr_minmax) begin
                    r_min <= w_code;
                    r_max <= w_code;
                end else begin
                    r_min <= (w_code < r_min) ? w_code : r_min;
                    r_max <= (w_code > r_max) ? w_code : r_max;
                end
            end else if (clr_minmax) begin
                r_min <= 12'hFFF;
                r_max <= 12'h000;
            end
        end
    end

    // Window accumulator, average and alarm hysteresis
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= {ACC_W{1'b0}};
            r_win       <= {CNT_W{1'b0}};
            r_avg       <= 12'h000;
            r_avg_valid <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (w_take) begin
                if (r_win == WIN_LAST) begin
                    r_avg       <= w_avg_new;
                    r_avg_valid <= 1'b1;
                    r_acc       <= {ACC_W{1'b0}};
                    r_win       <= {CNT_W{1'b0}};
                    if (w_avg_new >= ALARM_HI) begin
                        r_alarm <= 1'b1;
                    end else if (w_avg_new < ALARM_LO) begin
                        r_alarm <= 1'b0;
                    end
                end else begin
                    r_acc <= w_sum;
                    r_win <= r_win + CNT_W'(1);
                end
            end
        end
    end

    assign rd           = r_rd;
    assign wr           = r_wr;
    assign addr         = r_addr;
    assign data_in      = r_data_in;
    assign cfg_done     = r_cfg_done;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign avg          = r_avg;
    assign avg_valid    = r_avg_valid;
    assign min_code     = r_min;
    assign max_code     = r_max;
    assign alarm        = r_alarm;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_xadc_sample_ctrl.sv
`timescale 1ns/1ps
module tb_xadc_sample_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clr_minmax = 1'b0;
    logic        rd, wr, cfg_done, sample_valid, avg_valid, alarm, timeout_err;
    logic [6:0]  addr;
    logic [15:0] data_in;
    logic [15:0] fsm_data = 16'h0000;
    logic        fsm_valid = 1'b0;
    logic [11:0] sample, avg, min_code, max_code;

    always #5 clk = ~clk;

    xadc_sample_ctrl #(.SAMPLE_DIV(10), .AVG_LOG2(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_minmax(clr_minmax),
        .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .fsm_data(fsm_data), .fsm_valid(fsm_valid), .cfg_done(cfg_done),
        .sample(sample), .sample_valid(sample_valid), .avg(avg), .avg_valid(avg_valid),
        .min_code(min_code), .max_code(max_code), .alarm(alarm), .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- handshake model + scoreboard ----------------
    typedef struct packed { logic [11:0] s; logic [11:0] mn; logic [11:0] mx; } samp_t;
    typedef struct packed { logic [11:0] a; logic al; } avg_t;

    logic [11:0] code_q[$];
    samp_t       sq[$];
    avg_t        aq[$];
    bit          m_dead = 1'b0;
    bit          req_clr = 1'b0;
    bit          m_hold = 1'b0;
    bit          fire;
    int          m_age = 0;
    logic [13:0] m_acc = 14'h0;
    int          m_n = 0;
    logic [11:0] m_min = 12'hFFF, m_max = 12'h000, t_code, t_avg;
    logic        m_alarm = 1'b0;
    samp_t       e_s;
    avg_t        e_a;
    int          n_sv = 0, n_av = 0, cyc = 0, rd_in_cfg = 0;
    int          last_rise = -1, min_gap = 1000000;
    bit          prev_rd = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            fsm_valid = 1'b0; clr_minmax = 1'b0; m_age = 0; m_hold = 1'b0;
            m_acc = 14'h0; m_n = 0; m_min = 12'hFFF; m_max = 12'h000; m_alarm = 1'b0;
            sq.delete(); aq.delete(); prev_rd = 1'b0; last_rise = -1;
        end else begin
            if (sample_valid) begin
                n_sv++;
                check("sample_expected", 32'(sq.size() != 0), 32'd1);
                if (sq.size() != 0) begin
                    e_s = sq.pop_front();
                    check("sample", sample, e_s.s);
                    check("min_code", min_code, e_s.mn);
                    check("max_code", max_code, e_s.mx);
                end
            end
            if (avg_valid) begin
                n_av++;
                check("avg_expected", 32'(aq.size() != 0), 32'd1);
                if (aq.size() != 0) begin
                    e_a = aq.pop_front();
                    check("avg", avg, e_a.a);
                    check("alarm", alarm, e_a.al);
                end
            end
            if (rd && !cfg_done) rd_in_cfg++;
            if (rd && !prev_rd) begin
                if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
                last_rise = cyc;
            end
            prev_rd = rd;

            // handshake: accepts after 3 cycles, valid 2 cycles later
            fsm_valid = 1'b0; clr_minmax = 1'b0; fire = 1'b0;
            if (m_hold) begin
                if (!rd && !wr) m_hold = 1'b0;
            end else if (wr || (rd && !m_dead)) begin
                m_age++;
                if (m_age == 5) begin fire = 1'b1; m_age = 0; m_hold = 1'b1; end
            end else begin
                m_age = 0;
            end
            if (fire) begin
                fsm_valid = 1'b1;
                if (wr) begin
                    fsm_data = 16'($urandom);
                end else begin
                    t_code = (code_q.size() > 0) ? code_q.pop_front() : 12'h5A5;
                    fsm_data = {t_code, 4'($urandom)};
                    if (req_clr) begin
                        clr_minmax = 1'b1; req_clr = 1'b0; m_min = t_code; m_max = t_code;
                    end else begin
                        if (t_code < m_min) m_min = t_code;
                        if (t_code > m_max) m_max = t_code;
                    end
                    sq.push_back('{t_code, m_min, m_max});
                    m_acc = m_acc + 14'(t_code);
                    m_n++;
                    if (m_n == 4) begin
                        t_avg = m_acc[13:2];
                        if (t_avg >= 12'hB00) m_alarm = 1'b1;
                        else if (t_avg < 12'hAC0) m_alarm = 1'b0;
                        aq.push_back('{t_avg, m_alarm});
                        m_acc = 14'h0; m_n = 0;
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic check_reset(input string p);
        check({p, "_rd"}, rd, 32'd0);            check({p, "_wr"}, wr, 32'd0);
        check({p, "_addr"}, addr, 32'd0);        check({p, "_data_in"}, data_in, 32'd0);
        check({p, "_cfg_done"}, cfg_done, 32'd0); check({p, "_sample"}, sample, 32'd0);
        check({p, "_sample_valid"}, sample_valid, 32'd0);
        check({p, "_avg"}, avg, 32'd0);          check({p, "_avg_valid"}, avg_valid, 32'd0);
        check({p, "_min"}, min_code, 32'hFFF);   check({p, "_max"}, max_code, 32'd0);
        check({p, "_alarm"}, alarm, 32'd0);      check({p, "_timeout_err"}, timeout_err, 32'd0);
    endtask

    task automatic check_config(input string p);
        int g;
        g = 0; while (wr !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        check({p, "_cfg0_wr"}, wr, 32'd1);
        check({p, "_cfg0_addr"}, addr, 32'h40);
        check({p, "_cfg0_data"}, data_in, 32'h0003);
        g = 0; while (wr === 1'b1 && g < 200) begin @(negedge clk); g++; end
        check({p, "_rel_wr"}, wr, 32'd0);
        check({p, "_rel_cfg_done"}, cfg_done, 32'd0);
        @(negedge clk);
        check({p, "_cfg1_wr"}, wr, 32'd1);
        check({p, "_cfg1_addr"}, addr, 32'h41);
        check({p, "_cfg1_data"}, data_in, 32'h2000);
        g = 0; while (wr === 1'b1 && g < 200) begin @(negedge clk); g++; end
        check({p, "_rel2_wr"}, wr, 32'd0);
        check({p, "_rel2_cfg_done"}, cfg_done, 32'd0);
        @(negedge clk);
        check({p, "_cfg_done"}, cfg_done, 32'd1);
        check({p, "_no_rd_in_cfg"}, rd_in_cfg, 32'd0);
    endtask

    task automatic wait_av(input int n);
        int g;
        g = 0; while (n_av < n && g < 2000) begin @(negedge clk); g++; end
        check("avg_arrived", 32'(n_av >= n), 32'd1);
    endtask

    initial begin
        int g, n, rd_len, sv0;
        code_q = '{12'h100, 12'h200, 12'h300, 12'h401,
                   12'hB00, 12'hB00, 12'hB00, 12'hB00,
                   12'hAD0, 12'hAD0, 12'hAD0, 12'hAD0,
                   12'hABF, 12'hABF, 12'hABF, 12'hABF};
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // configuration writes with enable low
        check_config("boot");

        // enable low: no reads
        n = 0;
        repeat (5000) begin @(negedge clk); if (rd) n++; end
        check("no_rd_disabled", n, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("rd_after_enable", rd, 32'd1);

        // first window: 0x100,0x200,0x300,0x401
        wait_av(1);
        check("win1_avg", avg, 32'h280);
        check("win1_min", min_code, 32'h100);
        check("win1_max", max_code, 32'h401);
        check("win1_sv_count", 32'(n_sv >= 4), 32'd1);

        // alarm hysteresis
        wait_av(2);
        check("win2_avg", avg, 32'hB00);   check("win2_alarm", alarm, 32'd1);
        wait_av(3);
        check("win3_avg", avg, 32'hAD0);   check("win3_alarm", alarm, 32'd1);
        wait_av(4);
        check("win4_avg", avg, 32'hABF);   check("win4_alarm", alarm, 32'd0);
        check("read_gap_ge_div", 32'(min_gap >= 10), 32'd1);

        // clr_minmax coinciding with a sample
        @(posedge clk); req_clr = 1'b1;
        sv0 = n_sv;
        g = 0; while (n_sv <= sv0 && g < 200) begin @(negedge clk); g++; end
        @(negedge clk);
        check("clr_min", min_code, 32'h5A5);
        check("clr_max", max_code, 32'h5A5);

        // read timeout
        g = 0; while (rd !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        @(posedge clk); m_dead = 1'b1;
        sv0 = n_sv;
        rd_len = 1;
        @(negedge clk);
        g = 0; while (rd === 1'b1 && g < 5000) begin rd_len++; @(negedge clk); g++; end
        check("timeout_rd_len", rd_len, 32'd4096);
        check("timeout_err_set", timeout_err, 32'd1);
        check("timeout_rel_rd", rd, 32'd0);
        @(posedge clk); m_dead = 1'b0;
        @(negedge clk);
        check("timeout_no_sample", n_sv - sv0, 32'd0);
        g = 0; while (n_sv <= sv0 && g < 200) begin @(negedge clk); g++; end
        check("after_timeout_sample", sample, 32'h5A5);
        check("timeout_err_sticky", timeout_err, 32'd1);

        // async reset in the middle of a read
        g = 0; while (rd !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        check("rd_before_reset", rd, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset("midread");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_config("reboot");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
